// File: rtl/nios_system_pio_out_pkg.sv
// Shared constants for the Avalon-MM output PIO: register addresses, CTRL write
// bit positions, STATUS read bit positions and the pulse FSM state type.
package nios_system_pio_out_pkg;

  // Register word addresses
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_LEN      = 3'd2;
  localparam logic [2:0] ADDR_CTRL     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  // CTRL write bits
  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_ABORT   = 1;
  localparam int unsigned CTRL_CLRDONE = 2;
  localparam int unsigned CTRL_IRQEN   = 3;

  // STATUS read bits
  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_DONE      = 1;
  localparam int unsigned STAT_IRQEN     = 3;
  localparam int unsigned STAT_COUNT_LSB = 16;

  typedef enum logic {
    StIdle  = 1'b0,
    StPulse = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/nios_system_pio_out_pulse_timer.sv
// Timed-pulse FSM and down-counter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : load count from len_i (ignored when len_i is zero)
//   abort_i       : return to idle without signalling completion; beats start_i
//   len_i         : pulse length in clocks
//   busy_o        : high for exactly len_i clocks after a start
//   count_o       : remaining clocks of the current pulse (0 when idle)
//   done_set_o    : one-cycle strobe on the edge the pulse completes naturally
module nios_system_pio_out_pulse_timer
  import nios_system_pio_out_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic [LEN_WIDTH-1:0] count_o,
  output logic                 done_set_o
);

  pulse_state_e         state_q, state_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    done_set_o = 1'b0;
    if (abort_i) begin
      state_d = StIdle;
      count_d = '0;
    end else if (start_i && (len_i != '0)) begin
      // Covers both the initial start and a retrigger while pulsing
      state_d = StPulse;
      count_d = len_i;
    end else if (state_q == StPulse) begin
      if (count_q == LEN_WIDTH'(1)) begin
        state_d    = StIdle;
        count_d    = '0;
        done_set_o = 1'b1;
      end else begin
        count_d = count_q - LEN_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign busy_o  = (state_q == StPulse);
  assign count_o = count_q;

endmodule

// File: rtl/nios_system_pio_out.sv
// Avalon-MM slave output PIO. Drives out_port from a DATA register, with atomic
// set/clear, and a timed pulse that XORs MASK onto the outputs for LEN clocks.
//   clk, reset_n            : clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata      : Avalon-MM slave write interface
//   readdata                : registered read data, 1-cycle latency, no read strobe
//   out_port                : PIO outputs, register-driven only
//   irq                     : level interrupt, done & irq_en
module nios_system_pio_out
  import nios_system_pio_out_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH  = 18,
  parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0,
  parameter int unsigned            LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  done_q, done_d;
  logic                  irq_en_q, irq_en_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  wr_en;
  logic                  ctrl_wr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic [LEN_WIDTH-1:0]  count;
  logic                  done_set;
  logic                  unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign ctrl_wr      = wr_en && (address == ADDR_CTRL);
  assign wdata        = writedata[DATA_WIDTH-1:0];
  assign unused_wdata = ^writedata;

  nios_system_pio_out_pulse_timer #(
    .LEN_WIDTH (LEN_WIDTH)
  ) u_pulse_timer (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .start_i    (ctrl_wr & writedata[CTRL_START]),
    .abort_i    (ctrl_wr & writedata[CTRL_ABORT]),
    .len_i      (len_q),
    .busy_o     (busy),
    .count_o    (count),
    .done_set_o (done_set)
  );

  // Register writes
  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    len_d    = len_q;
    irq_en_d = irq_en_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_d   = wdata;
        ADDR_MASK:     mask_d   = wdata;
        ADDR_LEN:      len_d    = writedata[LEN_WIDTH-1:0];
        ADDR_CTRL:     irq_en_d = writedata[CTRL_IRQEN];
        ADDR_OUTSET:   data_d   = data_q | wdata;
        ADDR_OUTCLEAR: data_d   = data_q & ~wdata;
        default:       ;
      endcase
    end
  end

  // Natural completion takes priority over a simultaneous clear
  always_comb begin
    done_d = done_q;
    if (ctrl_wr && writedata[CTRL_CLRDONE]) begin
      done_d = 1'b0;
    end
    if (done_set) begin
      done_d = 1'b1;
    end
  end

  // Read mux samples pre-write state every clock
  always_comb begin
    rdata_d = '0;
    case (address)
      ADDR_DATA: rdata_d[DATA_WIDTH-1:0] = data_q;
      ADDR_MASK: rdata_d[DATA_WIDTH-1:0] = mask_q;
      ADDR_LEN:  rdata_d[LEN_WIDTH-1:0]  = len_q;
      ADDR_CTRL: begin
        rdata_d[STAT_BUSY]                        = busy;
        rdata_d[STAT_DONE]                        = done_q;
        rdata_d[STAT_IRQEN]                       = irq_en_q;
        rdata_d[STAT_COUNT_LSB +: LEN_WIDTH]      = count;
      end
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      len_q    <= '0;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      len_q    <= len_d;
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
      rdata_q  <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign out_port = data_q ^ (busy ? mask_q : '0);
  assign irq      = done_q & irq_en_q;

endmodule

// File: doc/nios_system_pio_out.md
Name: nios_system_pio_out

Overview:
Avalon-MM slave output PIO, the write-side counterpart of the system's input PIOs; drives a DATA_WIDTH-bit out_port (LEDs, GPIO) from the Nios II processor.
- Supports full-word write, atomic bit set/clear, and a hardware timed pulse that XORs a mask onto the outputs for an exact number of clocks.
- Raises an optional completion interrupt when a timed pulse ends.

Parameters:
DATA_WIDTH, 18, width of out_port and of the DATA/MASK registers (1..32)
RESET_VALUE, 0, value loaded into DATA on reset
LEN_WIDTH, 16, width of the pulse-length register and down-counter (1..16)

Ports:
clk  input  1  system clock; one clock domain, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
address  input  3  word address of register
chipselect  input  1  slave select
write_n  input  1  active-low write strobe; write occurs when chipselect=1 and write_n=0
writedata  input  32  write data; bits above the register width are ignored
readdata  output  32  registered read data
out_port  output  DATA_WIDTH  PIO output
irq  output  1  level interrupt = done & irq_en

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - DATA=RESET_VALUE; MASK=0; LEN=0; count=0; state=IDLE; done=0; irq_en=0.
  - readdata=0; out_port=RESET_VALUE; irq=0.
  - Reset mid-pulse aborts the pulse immediately.
- Register map (unused bits read 0):
  - 0 DATA, RW.
  - 1 MASK, RW.
  - 2 LEN, RW, [LEN_WIDTH-1:0].
  - 3 CTRL/STATUS:
    - write: bit0 start, bit1 abort, bit2 clear-done, bit3 irq_en.
    - read: bit0 busy, bit1 done, bit3 irq_en, [16+LEN_WIDTH-1:16] remaining count.
  - 4 OUTSET, W: DATA |= writedata.
  - 5 OUTCLEAR, W: DATA &= ~writedata.
  - 4–7 read as 0; writes to 6–7 are ignored.
- Read:
  - readdata <= mux(address) on every clock, with no read strobe.
  - Latency is 1 cycle. The value reflects register state before any write in the same cycle.
- out_port = DATA ^ (busy ? MASK : 0), driven from registers only (no combinational path from the bus).
  - A write sampled at edge N is visible on out_port after edge N.
- Pulse FSM, states IDLE and PULSE:
  - IDLE -> PULSE: start=1, abort=0, LEN!=0. Load count<=LEN.
  - start with LEN=0: no effect; state stays IDLE; done is unchanged.
  - PULSE: count decrements each cycle. On the edge where count==1, go to IDLE, set count=0, set done=1. busy is therefore high for exactly LEN cycles.
  - start while in PULSE: reload count<=LEN (retrigger); done is unchanged.
  - abort (any state): go to IDLE, count=0, done is NOT set. abort wins over a simultaneous start.
  - LEN writes during PULSE do not affect the running count. MASK and DATA writes during PULSE take effect on out_port immediately (next edge).
- done / irq_en:
  - clear-done=1 clears done.
  - If natural completion coincides with clear-done, done=1 (set wins).
  - Every CTRL write loads irq_en from writedata bit3.
- Width rules:
  - DATA, MASK, and LEN writes truncate writedata.
  - Reads zero-extend to 32 bits.
  - count never wraps below 0.

Decomposition:
- Package nios_system_pio_out_pkg holds:
  - address constants ADDR_DATA..ADDR_OUTCLEAR;
  - CTRL bit positions CTRL_START, CTRL_ABORT, CTRL_CLRDONE, CTRL_IRQEN;
  - STATUS bit positions;
  - state enum {IDLE, PULSE}.
- One sub-module, nios_system_pio_out_pulse_timer: the FSM plus the down-counter.
  - inputs: start, abort, len;
  - outputs: busy, count, done_set.
- The top level keeps the registers, read mux, and out_port logic.

Test Plan:
- Reset, then read addr 0 -> readdata=0x00000000 one cycle after address is applied; out_port=0, irq=0. Write DATA=0x3FFFF -> out_port=0x3FFFF next edge; readback 0x0003FFFF.
- DATA=0x00F0; OUTSET 0x0003 -> out_port=0x00F3; OUTCLEAR 0x0030 -> out_port=0x00C3; write to addr 6 -> no change.
- MASK=0x1, LEN=5, CTRL=0x9 (start+irq_en) -> out_port bit0 inverted for exactly 5 cycles; STATUS remaining count reads 5,4,3,2,1; then busy=0, done=1, irq=1; CTRL=0xC -> irq=0, irq_en stays 1.
- LEN=0, start -> busy stays 0, out_port unchanged. LEN=10, start, then at count=3 write LEN=2 and start -> busy lasts 2 more cycles.
- LEN=8, start; after 3 cycles CTRL=0x3 (start+abort) -> busy=0 next edge, done=0, out_port=DATA.
- LEN=100, start; assert reset_n=0 mid-pulse -> out_port=RESET_VALUE and readdata=0 immediately (asynchronous); after release, busy=0 and irq=0.
